// File: rtl/lsu_dmem_if.sv
// Load/store unit bridge to a word-wide data memory: sub-word, misaligned and split accesses.
// Latency: aligned load 3 cycles, aligned store 2 cycles; each split access adds one grant/rvalid round.
// Backpressure: o_busy stalls the core; requests hold on o_mem_* until i_mem_gnt, loads wait for rvalid.
module lsu_dmem_if (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_dmem_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lsu_size,
    input  logic        i_lsu_signed,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  size;
        logic        zext;
    } lsu_req_t;

    state_t      state, state_nxt;
    lsu_req_t    req_q;
    logic [31:0] w0_q;

    logic [1:0]  off;
    logic [2:0]  nbytes;
    logic [3:0]  mask;
    logic        split;
    logic [5:0]  sh;
    logic [31:0] base_addr;
    logic [31:0] w0, w1, rd_word, load_val;
    logic        accept, illegal, rd_last;

    assign off       = req_q.addr[1:0];
    assign sh        = {1'b0, off, 3'b000};
    assign base_addr = {req_q.addr[31:2], 2'b00};
    assign split     = ({1'b0, off} + nbytes) > 3'd4;

    assign illegal = (state == IDLE) && i_req && (i_lsu_size == 2'b11);
    assign accept  = (state == IDLE) && i_req && (i_lsu_size != 2'b11);
    assign rd_last = i_mem_rvalid && (((state == WAIT0) && !split) || (state == WAIT1));

    always_comb begin
        case (req_q.size)
            2'b00:   begin nbytes = 3'd1; mask = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; mask = 4'b0011; end
            default: begin nbytes = 3'd4; mask = 4'b1111; end
        endcase
    end

    // The word arriving this cycle is used directly so o_rdata is valid in DONE.
    assign w0      = (state == WAIT0) ? i_mem_rdata : w0_q;
    assign w1      = (state == WAIT1) ? i_mem_rdata : 32'h0;
    assign rd_word = (w0 >> sh) | (w1 << (6'd32 - sh));

    always_comb begin
        case (req_q.size)
            2'b00:   load_val = req_q.zext ? {24'h0, rd_word[7:0]}
                                           : {{24{rd_word[7]}}, rd_word[7:0]};
            2'b01:   load_val = req_q.zext ? {16'h0, rd_word[15:0]}
                                           : {{16{rd_word[15]}}, rd_word[15:0]};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = 32'h0;
        o_mem_be    = 4'b0000;
        o_mem_wdata = 32'h0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = REQ0;
            end
            REQ0: begin
                o_mem_req   = 1'b1;
                o_mem_we    = req_q.we;
                o_mem_addr  = base_addr;
                o_mem_be    = mask << off;
                o_mem_wdata = req_q.wdata << sh;
                if (i_mem_gnt) begin
                    if (!req_q.we) state_nxt = WAIT0;
                    else           state_nxt = split ? REQ1 : DONE;
                end
            end
            WAIT0: begin
                if (i_mem_rvalid) state_nxt = split ? REQ1 : DONE;
            end
            REQ1: begin
                // Second word of a split access; address wraps naturally at 2^32.
                o_mem_req   = 1'b1;
                o_mem_we    = req_q.we;
                o_mem_addr  = base_addr + 32'd4;
                o_mem_be    = mask >> (3'd4 - {1'b0, off});
                o_mem_wdata = req_q.wdata >> (6'd32 - sh);
                if (i_mem_gnt) state_nxt = req_q.we ? DONE : WAIT1;
            end
            WAIT1: begin
                if (i_mem_rvalid) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            req_q   <= '0;
            w0_q    <= 32'h0;
            o_err   <= 1'b0;
            o_rdata <= 32'h0;
        end else begin
            o_err <= illegal;
            if (accept) begin
                req_q.addr  <= i_addr;
                req_q.wdata <= i_wdata;
                req_q.we    <= i_dmem_we;
                req_q.size  <= i_lsu_size;
                req_q.zext  <= i_lsu_signed;
            end
            if ((state == WAIT0) && i_mem_rvalid) w0_q <= i_mem_rdata;
            if (rd_last) o_rdata <= load_val;
        end
    end

endmodule

// File: doc/lsu_dmem_if.md
LSU_DMEM_IF -- requirements
Module: lsu_dmem_if

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_reset, input, 1, synchronous active-low reset.
REQ-003 SHALL have port i_req, input, 1, core requests a load/store this cycle; sampled only in IDLE.
REQ-004 SHALL have port i_dmem_we, input, 1, 1 = store, 0 = load.
REQ-005 SHALL have port i_addr, input, 32, byte address (ALU result).
REQ-006 SHALL have port i_wdata, input, 32, store data; low bytes are used.
REQ-007 SHALL have port i_lsu_size, input, 2, funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port i_lsu_signed, input, 1, funct3[2]: 1 = zero-extend load (LBU/LHU), 0 = sign-extend; ignored for stores.
REQ-009 SHALL have port o_busy, output, 1, high whenever state != IDLE; core stalls on it.
REQ-010 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port o_err, output, 1, one-cycle pulse on illegal size.
REQ-012 SHALL have port o_rdata, output, 32, extended load result.
REQ-013 SHALL have port o_mem_req, output, 1, memory request.
REQ-014 SHALL have port o_mem_we, output, 1, memory write enable.
REQ-015 SHALL have port o_mem_addr, output, 32, word-aligned address with [1:0] = 00.
REQ-016 SHALL have port o_mem_be, output, 4, byte enables.
REQ-017 SHALL have port o_mem_wdata, output, 32, lane-aligned store data.
REQ-018 SHALL have port i_mem_gnt, input, 1, request accepted.
REQ-019 SHALL have port i_mem_rvalid, input, 1, read data valid.
REQ-020 SHALL have port i_mem_rdata, input, 32, read data.

Function
REQ-021 SHALL implement FSM states IDLE, REQ0, WAIT0, REQ1, WAIT1 and DONE.
REQ-022 SHALL, in IDLE with i_req=1 and size!=11, capture addr, wdata, we, size and signed, then go to REQ0.
REQ-023 SHALL, in IDLE with i_req=1 and size=11, pulse o_err the next cycle, issue no memory request, and stay in IDLE.
REQ-024 SHALL derive n = 1/2/4 bytes from size and off = addr[1:0]; the access is split when off+n > 4.
REQ-025 SHALL drive, in REQ0, addr[31:2]<<2 on o_mem_addr, be = (mask_n<<off)[3:0], and wdata << 8*off.
REQ-026 SHALL drive, in REQ1, o_mem_addr = first address + 4 (wraps modulo 2^32), be = mask_n>>(4-off), and wdata >> 8*(4-off).
REQ-027 SHALL hold o_mem_req and all o_mem_* signals stable in REQx until i_mem_gnt=1, and drive o_mem_req=0 in all other states.
REQ-028 SHALL, on a store grant, go to REQ1 if split, else to DONE.
REQ-029 SHALL, on a load grant, go to the matching WAITx.
REQ-030 SHALL sample i_mem_rvalid only in WAITx; rvalid in any other state is ignored.
REQ-031 SHALL, on rvalid in WAIT0, store the word, then go to REQ1 if split, else to DONE.
REQ-032 SHALL, on rvalid in WAIT1, store the second word, then go to DONE.
REQ-033 SHALL form the load result as (w0 >> 8*off) | (w1 << 8*(4-off)), take the low n bytes, and sign- or zero-extend them per i_lsu_signed.
REQ-034 SHALL, in DONE, pulse o_done, update o_rdata for loads (stores leave it unchanged), and return to IDLE.
REQ-035 SHALL give minimum latency from i_req to o_done of 3 cycles for an aligned load (gnt at once, rvalid next cycle) and 2 cycles for an aligned store.
REQ-036 SHALL accept no new request until back in IDLE; i_req while busy is ignored.

Reset
REQ-037 SHALL, on i_reset=0 at a clock edge in any state, enter IDLE and clear o_busy, o_done, o_err, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata and o_rdata to 0.
REQ-038 SHALL discard an in-flight transaction on reset mid-operation; a late rvalid after reset is ignored.

Verification
REQ-039 SHALL cover an aligned LW at 0x100, mem word 0x8000_00F0 -> be=1111, o_rdata=0x8000_00F0, o_done at cycle +3.
REQ-040 SHALL cover an LB at 0x103 with word 0x8000_00F0 -> be=1000, o_rdata=0xFFFF_FF80; the same access as LBU -> o_rdata=0x0000_0080.
REQ-041 SHALL cover an SH at 0x102 with wdata 0x1234_ABCD -> one access, be=1100, o_mem_wdata=0xABCD_0000.
REQ-042 SHALL cover a split LW at 0x0FE with words 0x1122_3344 then 0x5566_7788 -> two requests at 0x0FC then 0x100, be=1100 then 0011, o_rdata=0x7788_1122.
REQ-043 SHALL cover an illegal size 11 -> o_err pulse, o_mem_req stays 0, o_busy stays 0.
REQ-044 SHALL cover reset asserted in WAIT0, then rvalid one cycle after release -> IDLE, no o_done, o_rdata=0.
